// File: rtl/ysyx_22040759_ifu_pkg.sv
// Shared types and constants for the ysyx_22040759 instruction fetch unit:
// FSM state encoding, default reset PC and instruction width.
package ysyx_22040759_ifu_pkg;

    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;
    localparam int          INST_W           = 32;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_WAIT_RESP = 3'd1,
        ST_HOLD      = 3'd2,
        ST_WAIT_NPC  = 3'd3,
        ST_HALT      = 3'd4
    } ifu_state_e;

    // Instructions are 4-byte aligned, so only the two low address bits matter.
    function automatic logic pc_misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_22040759_ifu_pcreg.sv
// Architectural PC register with load enable and a sticky misalignment flag;
// a misaligned load leaves the PC untouched and only raises the flag.
module ysyx_22040759_ifu_pcreg
    import ysyx_22040759_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic [63:0] npc,
    output logic [63:0] pc,
    output logic        npc_bad,
    output logic        misalign
);

    logic [63:0] pc_d, pc_q;
    logic        misalign_d, misalign_q;

    always_comb begin
        npc_bad    = pc_misaligned(npc[1:0]);
        pc_d       = pc_q;
        misalign_d = misalign_q;
        if (load_en) begin
            if (npc_bad) begin
                misalign_d = 1'b1;
            end else begin
                pc_d = npc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc       = pc_q;
    assign misalign = misalign_q;

endmodule

// File: rtl/ysyx_22040759_ifu.sv
// Instruction fetch unit: one outstanding imem request, instruction held for
// decode, then waits for the next PC. Define YSYX_22040759_IFU_PERF_EN for perf counters.
module ysyx_22040759_ifu
    import ysyx_22040759_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              npc_valid,
    input  logic [63:0]       npc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [63:0]       imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_inst,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [63:0]       pc_out,
    output logic              misalign
`ifdef YSYX_22040759_IFU_PERF_EN
    ,
    output logic [63:0]       perf_fetch_cnt,
    output logic [63:0]       perf_stall_cnt
`endif
);

    ifu_state_e        state_d, state_q;
    logic [INST_W-1:0] inst_d, inst_q;
    logic [63:0]       pc;
    logic              pc_load;
    logic              npc_bad;

    ysyx_22040759_ifu_pcreg #(.RESET_PC(RESET_PC)) u_pcreg (
        .clk      (clk),
        .rst      (rst),
        .load_en  (pc_load),
        .npc      (npc),
        .pc       (pc),
        .npc_bad  (npc_bad),
        .misalign (misalign)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
        end
    end

    // Responses are only meaningful while a request is outstanding.
    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        pc_load = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (imem_req_ready) state_d = ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
                if (imem_resp_valid) begin
                    inst_d  = imem_resp_inst;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (inst_ready) begin
                    if (npc_valid) begin
                        pc_load = 1'b1;
                        state_d = npc_bad ? ST_HALT : ST_FETCH;
                    end else begin
                        state_d = ST_WAIT_NPC;
                    end
                end
            end
            ST_WAIT_NPC: begin
                if (npc_valid) begin
                    pc_load = 1'b1;
                    state_d = npc_bad ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    // Valids are masked while reset is asserted so nothing leaks in the reset cycle.
    always_comb begin
        imem_req_valid = !rst && (state_q == ST_FETCH);
        inst_valid     = !rst && (state_q == ST_HOLD);
        imem_req_addr  = pc;
        pc_out         = pc;
        inst           = inst_q;
    end

`ifdef YSYX_22040759_IFU_PERF_EN
    logic [63:0] perf_fetch_cnt_d, perf_fetch_cnt_q;
    logic [63:0] perf_stall_cnt_d, perf_stall_cnt_q;

    always_comb begin
        perf_fetch_cnt_d = perf_fetch_cnt_q;
        perf_stall_cnt_d = perf_stall_cnt_q;
        if (inst_valid && inst_ready) perf_fetch_cnt_d = perf_fetch_cnt_q + 64'd1;
        if ((state_q == ST_FETCH && !imem_req_ready) || state_q == ST_WAIT_RESP)
            perf_stall_cnt_d = perf_stall_cnt_q + 64'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt_q <= '0;
            perf_stall_cnt_q <= '0;
        end else begin
            perf_fetch_cnt_q <= perf_fetch_cnt_d;
            perf_stall_cnt_q <= perf_stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_cnt_q;
    assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_22040759_ifu.sv
// Self-checking bench for ysyx_22040759_ifu: directed scenarios plus a randomized
// transaction loop checked against a transaction-level PC model.
module tb_ysyx_22040759_ifu;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        npc_valid;
    logic [63:0] npc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] pc_out;
    logic        misalign;
`ifdef YSYX_22040759_IFU_PERF_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_22040759_ifu dut (
        .clk             (clk),
        .rst             (rst),
        .npc_valid       (npc_valid),
        .npc             (npc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_inst  (imem_resp_inst),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .pc_out          (pc_out),
        .misalign        (misalign)
`ifdef YSYX_22040759_IFU_PERF_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        rst = 1'b0; npc_valid = 1'b0; npc = '0; imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0; imem_resp_inst = '0; inst_ready = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1; imem_resp_valid = 1'b1; imem_resp_inst = $urandom;
        imem_req_ready = 1'b1; npc_valid = 1'b1; npc = {$urandom, $urandom}; inst_ready = 1'b1;
        next_cycle();
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_req_valid got=%0b exp=0", imem_req_valid); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_inst_valid got=%0b exp=0", inst_valid); end
        checks++; if (misalign !== 1'b0) begin failures++; $display("[TB] FAIL rst_misalign got=%0b exp=0", misalign); end
        checks++; if (pc_out !== RST_PC) begin failures++; $display("[TB] FAIL rst_pc got=%h exp=%h", pc_out, RST_PC); end
        checks++; if (inst !== 32'h0) begin failures++; $display("[TB] FAIL rst_inst got=%h exp=0", inst); end
        next_cycle();
        idle_inputs();
        imem_resp_valid = 1'b1; imem_resp_inst = 32'hDEAD_BEEF;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin failures++; $display("[TB] FAIL post_rst_req got=%0b/%h exp=1/%h", imem_req_valid, imem_req_addr, RST_PC); end
        next_cycle();
        idle_inputs();
        #1;
        checks++; if (inst !== 32'h0 || inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL early_resp_ignored got inst=%h valid=%0b exp=0/0", inst, inst_valid); end
    endtask

    task automatic test_first_fetch;
        do_reset();
        imem_req_ready = 1'b1; imem_resp_valid = 1'b1; imem_resp_inst = 32'hFFFF_FFFF;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin failures++; $display("[TB] FAIL first_req got=%0b/%h exp=1/80000000", imem_req_valid, imem_req_addr); end
        next_cycle();
        idle_inputs();
        imem_resp_valid = 1'b1; imem_resp_inst = 32'h0000_0413;
        #1;
        checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL wait_resp_valids got=%0b/%0b exp=0/0", imem_req_valid, inst_valid); end
        next_cycle();
        idle_inputs();
        #1;
        checks++; if (inst_valid !== 1'b1 || inst !== 32'h0000_0413 || pc_out !== 64'h8000_0000) begin failures++; $display("[TB] FAIL first_inst got=%0b/%h/%h exp=1/00000413/80000000", inst_valid, inst, pc_out); end
    endtask

    task automatic test_decode_stall;
        for (int i = 0; i < 4; i++) begin
            inst_ready = 1'b0; npc_valid = 1'b1; npc = 64'h8000_0102;
            #1;
            checks++; if (inst_valid !== 1'b1 || inst !== 32'h0000_0413 || pc_out !== 64'h8000_0000) begin failures++; $display("[TB] FAIL stall_hold[%0d] got=%0b/%h/%h exp=1/00000413/80000000", i, inst_valid, inst, pc_out); end
            next_cycle();
        end
        inst_ready = 1'b1; npc_valid = 1'b1; npc = 64'h8000_0004;
        #1;
        checks++; if (inst_valid !== 1'b1 || misalign !== 1'b0) begin failures++; $display("[TB] FAIL stall_accept got=%0b/%0b exp=1/0", inst_valid, misalign); end
        next_cycle();
        idle_inputs();
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0004) begin failures++; $display("[TB] FAIL stall_next_req got=%0b/%h exp=1/80000004", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_taken_branch;
        logic [31:0] w;
        w = $urandom;
        imem_req_ready = 1'b1;
        next_cycle(); idle_inputs();
        imem_resp_valid = 1'b1; imem_resp_inst = w;
        next_cycle(); idle_inputs();
        inst_ready = 1'b1;
        #1;
        checks++; if (inst_valid !== 1'b1 || inst !== w || pc_out !== 64'h8000_0004) begin failures++; $display("[TB] FAIL br_hold got=%0b/%h/%h exp=1/%h/80000004", inst_valid, inst, pc_out, w); end
        next_cycle(); idle_inputs();
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL wait_npc[%0d] got=%0b/%0b exp=0/0", i, inst_valid, imem_req_valid); end
            next_cycle();
        end
        npc_valid = 1'b1; npc = 64'h8000_0100;
        next_cycle(); idle_inputs();
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0100) begin failures++; $display("[TB] FAIL br_req got=%0b/%h exp=1/80000100", imem_req_valid, imem_req_addr); end
        w = $urandom;
        imem_req_ready = 1'b1;
        next_cycle(); idle_inputs();
        imem_resp_valid = 1'b1; imem_resp_inst = w;
        next_cycle(); idle_inputs();
        inst_ready = 1'b1; npc_valid = 1'b1; npc = 64'h8000_0104;
        #1;
        checks++; if (inst_valid !== 1'b1 || inst !== w || pc_out !== 64'h8000_0100) begin failures++; $display("[TB] FAIL br_target_hold got=%0b/%h/%h exp=1/%h/80000100", inst_valid, inst, pc_out, w); end
        next_cycle(); idle_inputs();
    endtask

    task automatic test_backpressure;
        logic [31:0] w;
        for (int i = 0; i < 5; i++) begin
            imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_inst = $urandom;
            #1;
            checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0104) begin failures++; $display("[TB] FAIL bp_hold[%0d] got=%0b/%h exp=1/80000104", i, imem_req_valid, imem_req_addr); end
            next_cycle();
        end
        idle_inputs();
        imem_req_ready = 1'b1;
        next_cycle(); idle_inputs();
        w = $urandom;
        imem_resp_valid = 1'b1; imem_resp_inst = w;
        next_cycle(); idle_inputs();
        #1;
        checks++; if (inst_valid !== 1'b1 || inst !== w || pc_out !== 64'h8000_0104) begin failures++; $display("[TB] FAIL bp_inst got=%0b/%h/%h exp=1/%h/80000104", inst_valid, inst, pc_out, w); end
    endtask

    task automatic test_misalign;
        inst_ready = 1'b1; npc_valid = 1'b1; npc = 64'h8000_0102;
        next_cycle(); idle_inputs();
        for (int i = 0; i < 3; i++) begin
            imem_req_ready = 1'b1; imem_resp_valid = 1'b1; imem_resp_inst = $urandom;
            npc_valid = 1'b1; npc = 64'h8000_0200; inst_ready = 1'b1;
            #1;
            checks++; if (misalign !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || pc_out !== 64'h8000_0104) begin failures++; $display("[TB] FAIL halt[%0d] got mis=%0b req=%0b iv=%0b pc=%h exp=1/0/0/80000104", i, misalign, imem_req_valid, inst_valid, pc_out); end
            next_cycle();
        end
        do_reset();
        #1;
        checks++; if (misalign !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin failures++; $display("[TB] FAIL halt_recover got mis=%0b req=%0b addr=%h exp=0/1/%h", misalign, imem_req_valid, imem_req_addr, RST_PC); end
        // Misaligned target delivered while waiting for the next PC.
        imem_req_ready = 1'b1;
        next_cycle(); idle_inputs();
        imem_resp_valid = 1'b1; imem_resp_inst = $urandom;
        next_cycle(); idle_inputs();
        inst_ready = 1'b1;
        next_cycle(); idle_inputs();
        npc_valid = 1'b1; npc = 64'h8000_0011;
        next_cycle(); idle_inputs();
        #1;
        checks++; if (misalign !== 1'b1 || imem_req_valid !== 1'b0 || pc_out !== RST_PC) begin failures++; $display("[TB] FAIL wait_npc_misalign got mis=%0b req=%0b pc=%h exp=1/0/%h", misalign, imem_req_valid, pc_out, RST_PC); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        imem_req_ready = 1'b1;
        next_cycle(); idle_inputs();
        rst = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_valids got=%0b/%0b exp=0/0", imem_req_valid, inst_valid); end
        next_cycle(); idle_inputs();
        imem_resp_valid = 1'b1; imem_resp_inst = 32'h1234_5678;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC || inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_refetch got=%0b/%h/%0b exp=1/%h/0", imem_req_valid, imem_req_addr, inst_valid, RST_PC); end
`ifdef YSYX_22040759_IFU_PERF_EN
        checks++; if (perf_fetch_cnt !== 64'd0 || perf_stall_cnt !== 64'd0) begin failures++; $display("[TB] FAIL mid_rst_perf got=%0d/%0d exp=0/0", perf_fetch_cnt, perf_stall_cnt); end
`endif
        next_cycle(); idle_inputs();
        #1;
        checks++; if (inst_valid !== 1'b0 || inst !== 32'h0 || imem_req_valid !== 1'b1) begin failures++; $display("[TB] FAIL mid_rst_dropped got iv=%0b inst=%h req=%0b exp=0/0/1", inst_valid, inst, imem_req_valid); end
    endtask

    // Transaction-level model: the bench plays memory, decode and branch unit,
    // and the expected PC is simply the last aligned next-PC it handed over.
    task automatic test_random;
        logic [63:0] model_pc, target;
        logic [31:0] word;
        longint unsigned exp_fetch, exp_stall;
        bit same;
        int r;
        do_reset();
        model_pc = RST_PC; exp_fetch = 0; exp_stall = 0;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
                imem_req_ready = 1'b0; imem_resp_valid = 1'($urandom); imem_resp_inst = $urandom;
                npc_valid = 1'($urandom); npc = {$urandom, $urandom};
                #1;
                checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== model_pc) begin failures++; $display("[TB] FAIL rnd_req_wait t=%0d got=%0b/%h exp=1/%h", t, imem_req_valid, imem_req_addr, model_pc); end
                exp_stall++;
                next_cycle();
            end
            idle_inputs();
            imem_req_ready = 1'b1;
            #1;
            checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== model_pc) begin failures++; $display("[TB] FAIL rnd_req t=%0d got=%0b/%h exp=1/%h", t, imem_req_valid, imem_req_addr, model_pc); end
            next_cycle(); idle_inputs();
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
                #1;
                checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL rnd_wait_resp t=%0d got=%0b/%0b exp=0/0", t, imem_req_valid, inst_valid); end
                exp_stall++;
                next_cycle();
            end
            word = $urandom;
            imem_resp_valid = 1'b1; imem_resp_inst = word;
            exp_stall++;
            next_cycle(); idle_inputs();
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
                inst_ready = 1'b0; npc_valid = 1'($urandom); npc = {$urandom, $urandom};
                imem_resp_valid = 1'($urandom); imem_resp_inst = $urandom;
                #1;
                checks++; if (inst_valid !== 1'b1 || inst !== word || pc_out !== model_pc) begin failures++; $display("[TB] FAIL rnd_hold t=%0d got=%0b/%h/%h exp=1/%h/%h", t, inst_valid, inst, pc_out, word, model_pc); end
                next_cycle();
            end
            idle_inputs();
            r = int'($urandom_range(0, 9));
            if (r < 6)      target = model_pc + 64'd4;
            else if (r < 9) target = {$urandom, $urandom} & ~64'h3;
            else            target = 64'hFFFF_FFFF_FFFF_FFFC;
            same = 1'($urandom);
            inst_ready = 1'b1; npc_valid = same; npc = target;
            #1;
            checks++; if (inst_valid !== 1'b1 || inst !== word || pc_out !== model_pc) begin failures++; $display("[TB] FAIL rnd_accept t=%0d got=%0b/%h/%h exp=1/%h/%h", t, inst_valid, inst, pc_out, word, model_pc); end
            exp_fetch++;
            next_cycle(); idle_inputs();
            if (!same) begin
                for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
                    #1;
                    checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL rnd_wait_npc t=%0d got=%0b/%0b exp=0/0", t, inst_valid, imem_req_valid); end
                    next_cycle();
                end
                npc_valid = 1'b1; npc = target;
                next_cycle(); idle_inputs();
            end
            model_pc = target;
        end
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== model_pc || misalign !== 1'b0) begin failures++; $display("[TB] FAIL rnd_final got=%0b/%h/%0b exp=1/%h/0", imem_req_valid, imem_req_addr, misalign, model_pc); end
`ifdef YSYX_22040759_IFU_PERF_EN
        checks++; if (perf_fetch_cnt !== exp_fetch) begin failures++; $display("[TB] FAIL perf_fetch got=%0d exp=%0d", perf_fetch_cnt, exp_fetch); end
        checks++; if (perf_stall_cnt !== exp_stall) begin failures++; $display("[TB] FAIL perf_stall got=%0d exp=%0d", perf_stall_cnt, exp_stall); end
`endif
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_first_fetch();
        test_decode_stall();
        test_taken_branch();
        test_backpressure();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_22040759_ifu.md
Name: ysyx_22040759_ifu

Overview:
- Instruction fetch unit. It owns the architectural PC register and fetches one instruction at a time from instruction memory over a valid/ready request and valid response port.
- It hands each instruction to decode with a valid/ready handshake.
- It then accepts the next PC (branch unit output: taken target or pc+4) through a valid strobe.
- It is the consumer end of the next-PC interface: the branch unit produces the next PC, and this block registers it and acts on it.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset; first fetch address.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- npc_valid  in  1  next-PC strobe from execute/branch stage.
- npc  in  64  next PC value (branch target or pc+4).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  64  fetch address (= current PC).
- imem_resp_valid  in  1  response valid, one cycle pulse.
- imem_resp_inst  in  32  fetched instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts instruction.
- inst  out  32  held instruction.
- pc_out  out  64  PC of held instruction; feeds the branch unit's pc input.
- misalign  out  1  sticky: an npc with npc[1:0]!=0 was received.

Behaviour:
- Reset (rst=1 at clk edge):
  - pc=RESET_PC, state=FETCH.
  - inst=0, inst_valid=0, imem_req_valid=0 in the reset cycle, misalign=0.
  - Reset mid-transaction abandons everything.
  - A response arriving in the first FETCH cycle after reset is ignored.
- States: FETCH, WAIT_RESP, HOLD, WAIT_NPC, HALT.
- FETCH:
  - imem_req_valid=1, imem_req_addr=pc.
  - On imem_req_ready=1 → WAIT_RESP.
  - imem_req_addr is stable while valid && !ready.
- WAIT_RESP:
  - imem_req_valid=0.
  - On imem_resp_valid=1: latch inst=imem_resp_inst → HOLD.
  - No timeout.
- HOLD:
  - inst_valid=1; inst and pc_out stable.
  - On inst_valid && inst_ready: if npc_valid is also 1 in the same cycle, load pc=npc → FETCH. Otherwise → WAIT_NPC.
  - npc_valid while inst_valid && !inst_ready is ignored.
- WAIT_NPC:
  - inst_valid=0.
  - On npc_valid: pc=npc → FETCH.
- Misaligned npc (npc[1:0]!=0) in any accepting state:
  - pc is not updated; misalign=1 (sticky until rst) → HALT.
- HALT:
  - All valids 0; leaves only on rst.
- Other rules:
  - pc_out always equals the pc register.
  - Minimum latency from npc accept to next inst_valid is 3 cycles, given ready=1 and a response the cycle after request acceptance.
  - No speculation; at most one outstanding request.
  - Responses outside WAIT_RESP are dropped.
  - No 64-bit wrap protection: the PC wraps naturally modulo 2^64.

Optional Feature:
- Macro YSYX_22040759_IFU_PERF_EN.
- Defined: adds outputs perf_fetch_cnt[63:0] and perf_stall_cnt[63:0], both reset to 0.
  - perf_fetch_cnt increments on each inst_valid && inst_ready.
  - perf_stall_cnt increments each cycle in FETCH with !imem_req_ready, or in WAIT_RESP.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared define file holds:
  - FSM state encodings (3-bit): FETCH=0, WAIT_RESP=1, HOLD=2, WAIT_NPC=3, HALT=4.
  - Default RESET_PC constant.
  - Instruction width (32).
- One natural sub-module, ysyx_22040759_ifu_pcreg: a 64-bit PC register with load-enable, synchronous reset to RESET_PC, and a misalign check.
- FSM and handshake logic stay in the top module.

Test Plan:
- Reset then ready=1, response next cycle with 32'h00000413:
  - imem_req_addr=64'h80000000.
  - inst_valid rises in the 3rd cycle after reset release, with inst=32'h00000413 and pc_out=64'h80000000.
- Decode holds inst_ready=0 for 4 cycles, then 1, with npc_valid=1 and npc=64'h80000004 in the ready cycle:
  - inst stable for all 4 cycles.
  - The next cycle shows FETCH with imem_req_addr=64'h80000004.
- Taken branch: npc=64'h80000100 delivered in WAIT_NPC → next request address is 64'h80000100; pc_out matches after the response.
- Back-pressure: imem_req_ready=0 for 5 cycles → imem_req_valid held and address stable; a spurious imem_resp_valid in FETCH is ignored.
- Misaligned npc=64'h80000102:
  - misalign=1, no further requests.
  - After a rst pulse, misalign=0 and fetch resumes at 64'h80000000.
- rst asserted in WAIT_RESP; response arrives the cycle after reset:
  - Response dropped, inst_valid stays 0.
  - New request issued at RESET_PC.
  - With PERF_EN defined, both counters read 0.
